// File: rtl/convert_sequencer.sv
// rtl/convert_sequencer.sv - digit entry, conversion handshake and display select sequencer
// Optional watchdog on the WAIT state is compiled in when CONV_SEQ_TIMEOUT_EN is defined.
module convert_sequencer #(
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enter_pulse,
  input  logic                  confirm_pulse,
  input  logic                  clear_pulse,
  input  logic [3:0]            nibble,
  output logic                  conv_req,
  output logic [4*DIGITS-1:0]   conv_data,
  input  logic                  conv_done,
  input  logic [15:0]           conv_result,
  input  logic                  conv_error,
  output logic [31:0]           show,
  output logic [7:0]            mask,
  output logic                  error,
  output logic                  busy,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    ST_ENTRY = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHOW  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [3:0] DIG_MAX = 4'(DIGITS);

  state_t      state_q;
  logic [31:0] entry_q;
  logic [3:0]  count_q;
  logic [7:0]  mask_q;
  logic [15:0] result_q;
  logic [31:0] show_q;
  logic        error_q;
  logic        req_q;
  logic        busy_q;

  // Shifted entry and mask used whenever a digit is accepted in ENTRY
  logic [31:0] entry_shift_d;
  logic [7:0]  mask_shift_d;
  logic        can_enter_d;

  // Precompute the effect of a digit shift so the sequential block stays readable
  always_comb begin
    entry_shift_d = {entry_q[27:0], nibble};
    mask_shift_d  = {mask_q[6:0], 1'b1};
    can_enter_d   = enter_pulse && (count_q < DIG_MAX);
  end

`ifdef CONV_SEQ_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wait_cnt_q;
`endif

  // Sequencer FSM; every output is a register so nothing passes straight from input to output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_ENTRY;
      entry_q  <= '0;
      count_q  <= '0;
      mask_q   <= '0;
      result_q <= '0;
      show_q   <= '0;
      error_q  <= 1'b0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef CONV_SEQ_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      req_q <= 1'b0;
      if (clear_pulse) begin
        // Clear drops the pending conversion; late done/error land outside WAIT and are ignored
        state_q  <= ST_ENTRY;
        entry_q  <= '0;
        count_q  <= '0;
        mask_q   <= '0;
        result_q <= '0;
        show_q   <= '0;
        error_q  <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_ENTRY: begin
            if (can_enter_d) begin
              entry_q <= entry_shift_d;
              count_q <= count_q + 4'd1;
              mask_q  <= mask_shift_d;
              show_q  <= entry_shift_d;
            end
            // A same-cycle enter counts toward the non-empty check
            if (confirm_pulse && (can_enter_d || count_q != 4'd0)) begin
              state_q <= ST_REQ;
              req_q   <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
          ST_REQ: begin
            state_q <= ST_WAIT;
`ifdef CONV_SEQ_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
          end
          ST_WAIT: begin
            if (conv_error) begin
              state_q <= ST_ERR;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
            end else if (conv_done) begin
              state_q  <= ST_SHOW;
              result_q <= conv_result;
              show_q   <= {16'h0, conv_result};
              mask_q   <= 8'h0F;
              busy_q   <= 1'b0;
`ifdef CONV_SEQ_TIMEOUT_EN
            end else if (wait_cnt_q == WD_LAST) begin
              state_q <= ST_ERR;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
            end else if (wait_cnt_q != 16'hFFFF) begin
              wait_cnt_q <= wait_cnt_q + 16'd1;
`endif
            end
          end
          ST_SHOW: begin
            if (enter_pulse) begin
              state_q <= ST_ENTRY;
              entry_q <= {28'h0, nibble};
              count_q <= 4'd1;
              mask_q  <= 8'h01;
              show_q  <= {28'h0, nibble};
            end
          end
          ST_ERR: begin
            state_q <= ST_ERR;
          end
          default: begin
            state_q <= ST_ENTRY;
          end
        endcase
      end
    end
  end

  assign conv_req  = req_q;
  assign conv_data = entry_q[4*DIGITS-1:0];
  assign show      = show_q;
  assign mask      = mask_q;
  assign error     = error_q;
  assign busy      = busy_q;
  assign state     = state_q;

endmodule

// File: tb/tb_convert_sequencer.sv
// tb/tb_convert_sequencer.sv - scoreboard bench for convert_sequencer against a digit-list model
module tb_convert_sequencer;
  localparam int DIGITS  = 4;
  localparam int TIMEOUT = 16;

  logic        clk;
  logic        reset;
  logic        enter_pulse;
  logic        confirm_pulse;
  logic        clear_pulse;
  logic [3:0]  nibble;
  logic        conv_req;
  logic [15:0] conv_data;
  logic        conv_done;
  logic [15:0] conv_result;
  logic        conv_error;
  logic [31:0] show;
  logic [7:0]  mask;
  logic        error;
  logic        busy;
  logic [2:0]  state;

  convert_sequencer #(.DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .enter_pulse(enter_pulse), .confirm_pulse(confirm_pulse),
    .clear_pulse(clear_pulse), .nibble(nibble), .conv_req(conv_req), .conv_data(conv_data),
    .conv_done(conv_done), .conv_result(conv_result), .conv_error(conv_error),
    .show(show), .mask(mask), .error(error), .busy(busy), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic [15:0] data;
    logic [31:0] show;
    logic [7:0]  mask;
    logic        err;
    logic        busy;
    logic [2:0]  st;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: the entry is a list of digits, the mode is a small integer
  int         m_mode;
  logic [3:0] m_digits[$];
  logic [15:0] m_result;
  int         m_waited;

  function automatic exp_t model_out();
    exp_t e;
    logic [31:0] ent;
    ent = 32'h0;
    foreach (m_digits[i]) ent = ent * 16 + 32'(m_digits[i]);
    e.req  = (m_mode == 1);
    e.busy = (m_mode == 1) || (m_mode == 2);
    e.err  = (m_mode == 4);
    e.data = ent[15:0];
    e.show = (m_mode == 3) ? {16'h0, m_result} : ent;
    e.mask = (m_mode == 3) ? 8'h0F : 8'((1 << m_digits.size()) - 1);
    e.st   = 3'(m_mode);
    return e;
  endfunction

  task automatic model_step(input logic en, input logic cf, input logic cl, input logic [3:0] nb,
                            input logic dn, input logic er, input logic [15:0] res);
    if (cl) begin
      m_mode = 0;
      m_digits.delete();
      m_result = 16'h0;
    end else begin
      case (m_mode)
        0: begin
          if (en && m_digits.size() < DIGITS) m_digits.push_back(nb);
          if (cf && m_digits.size() >= 1) m_mode = 1;
        end
        1: begin
          m_mode = 2;
          m_waited = 0;
        end
        2: begin
          if (er) m_mode = 4;
          else if (dn) begin
            m_result = res;
            m_mode = 3;
          end else begin
            m_waited++;
`ifdef CONV_SEQ_TIMEOUT_EN
            if (m_waited == TIMEOUT) m_mode = 4;
`endif
          end
        end
        3: begin
          if (en) begin
            m_digits.delete();
            m_digits.push_back(nb);
            m_mode = 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  // Drive one cycle of stimulus and queue the response it must produce
  task automatic step(input logic en, input logic cf, input logic cl, input logic [3:0] nb,
                      input logic dn, input logic er, input logic [15:0] res);
    @(negedge clk);
    enter_pulse = en; confirm_pulse = cf; clear_pulse = cl; nibble = nb;
    conv_done = dn; conv_error = er; conv_result = res;
    model_step(en, cf, cl, nb, dn, er, res);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 4'h0, 0, 0, 16'($urandom));
  endtask

  // Monitor: one registered response per driven cycle, checked just after the edge
  initial begin
    exp_t e;
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (conv_req !== e.req || conv_data !== e.data || show !== e.show || mask !== e.mask ||
            error !== e.err || busy !== e.busy || state !== e.st) begin
          n_fail++;
          $display("FAIL cycle%0d: got req=%b data=%h show=%h mask=%h err=%b busy=%b st=%0d want req=%b data=%h show=%h mask=%h err=%b busy=%b st=%0d",
                   cyc, conv_req, conv_data, show, mask, error, busy, state,
                   e.req, e.data, e.show, e.mask, e.err, e.busy, e.st);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    enter_pulse = 0; confirm_pulse = 0; clear_pulse = 0; nibble = 0;
    conv_done = 0; conv_error = 0; conv_result = 0;
    m_mode = 0; m_result = 0; m_waited = 0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (conv_req !== 0 || conv_data !== 0 || show !== 0 || mask !== 0 || error !== 0 ||
        busy !== 0 || state !== 0) begin
      n_fail++;
      $display("FAIL reset: got req=%b data=%h show=%h mask=%h err=%b busy=%b st=%0d want all zero",
               conv_req, conv_data, show, mask, error, busy, state);
    end
    @(negedge clk);
    reset = 1'b0;

    // Digit entry, full entry, confirm/request, result display and new entry
    step(1, 0, 0, 4'hA, 0, 0, 0);
    step(1, 0, 0, 4'hB, 0, 0, 0);
    step(1, 0, 0, 4'hC, 0, 0, 0);
    step(1, 0, 0, 4'hD, 0, 0, 0);
    step(1, 0, 0, 4'h5, 0, 0, 0);
    step(0, 1, 0, 4'h0, 0, 0, 0);
    step(1, 1, 0, 4'h3, 0, 0, 0);
    idle(3);
    step(0, 0, 0, 4'h0, 1, 0, 16'h4B3C);
    step(0, 1, 0, 4'h0, 0, 0, 0);
    step(1, 0, 0, 4'h7, 0, 0, 0);

    // Confirm with an empty entry is ignored; enter+confirm together starts a request
    step(0, 0, 1, 4'h0, 0, 0, 0);
    step(0, 1, 0, 4'h0, 0, 0, 0);
    step(1, 1, 0, 4'h2, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 4'h0, 1, 1, 16'h1234);
    step(1, 1, 0, 4'h1, 1, 0, 16'h5555);
    step(0, 0, 1, 4'h0, 0, 0, 0);

    // Clear during WAIT, then a late done three cycles later
    step(1, 0, 0, 4'h9, 0, 0, 0);
    step(0, 1, 0, 4'h0, 0, 0, 0);
    idle(2);
    step(0, 0, 1, 4'h0, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 4'h0, 1, 0, 16'hBEEF);
    step(0, 0, 0, 4'h0, 0, 1, 16'h0);

    // Watchdog: no response in WAIT
    step(1, 1, 0, 4'h6, 0, 0, 0);
`ifdef CONV_SEQ_TIMEOUT_EN
    idle(TIMEOUT + 4);
`else
    idle(1001);
`endif
    step(0, 0, 1, 4'h0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 4) == 0, ($urandom % 6) == 0, ($urandom % 50) == 0, 4'($urandom),
           ($urandom % 7) == 0, ($urandom % 25) == 0, 16'($urandom));
    end
    idle(1);

    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/convert_sequencer.md
# convert_sequencer

Sequencing controller between the debounced front-panel pulses, the IEEE754 conversion FSM and the seven-segment controller. Collects hex digits into an entry register, issues a one-cycle conversion request with a `conv_req`/`conv_done` handshake, and selects what the display shows: the entry, the 16-bit result, or the error state. Runs on the 100 MHz system clock and replaces ad-hoc request/show/mask registers at top level.

## Interface
- `DIGITS`, default 4: number of hex digits collected; legal range 1..8.
- `TIMEOUT`, default 1024: number of WAIT cycles before the watchdog fires; legal range 2..65535.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enter_pulse`  in  1  one-cycle pulse that shifts in `nibble`.
- `confirm_pulse`  in  1  one-cycle pulse that starts a conversion.
- `clear_pulse`  in  1  one-cycle pulse that aborts and clears everything.
- `nibble`  in  4  switch value sampled when `enter_pulse` is high.
- `conv_req`  out  1  one-cycle request to the conversion FSM.
- `conv_data`  out  4*DIGITS  entered digits, zero-padded on the left.
- `conv_done`  in  1  one-cycle result-valid pulse from the FSM.
- `conv_result`  in  16  result, valid only when `conv_done` is high.
- `conv_error`  in  1  error pulse from the FSM.
- `show`  out  32  value sent to the display.
- `mask`  out  8  digit enables; bit i high lights digit i.
- `error`  out  1  error indicator for the display.
- `busy`  out  1  high in REQ and WAIT.
- `state`  out  3  current state encoding, for debug.

## Operation
- States and encodings: ENTRY=0, REQ=1, WAIT=2, SHOW=3, ERR=4.
- Reset value of every output and register is zero, and the state is ENTRY.
- Priority order:
  - `clear_pulse` in any state forces ENTRY with the entry, digit count, mask, result, `show` and `error` all cleared.
  - `clear_pulse` overrides any other pulse in the same cycle.
  - If clear arrives in REQ or WAIT, a late `conv_done` or `conv_error` that follows is ignored.
- ENTRY:
  - `enter_pulse` with count < DIGITS: entry <= {entry[27:0], nibble}, count+1, mask <= {mask[6:0],1}.
  - `enter_pulse` with count == DIGITS: ignored (full), no change.
  - `confirm_pulse` with count == 0: ignored.
  - `confirm_pulse` with count >= 1: go to REQ.
  - `enter_pulse` and `confirm_pulse` in the same cycle: the enter is applied first, then the transition.
  - `show` = entry; `conv_data` = entry[4*DIGITS-1:0].
- REQ: `conv_req` is high for exactly this one cycle, then the state goes to WAIT unconditionally.
- WAIT:
  - `conv_error` goes to ERR.
  - Otherwise `conv_done` latches `conv_result` and goes to SHOW.
  - Error wins when both arrive in the same cycle.
  - `enter_pulse` and `confirm_pulse` are ignored.
  - `show` holds the entry.
- SHOW:
  - `show` = {16'h0, result}; `mask` = 8'h0F.
  - `enter_pulse` starts a new entry: entry = {28'h0, nibble}, count = 1, mask = 8'h01, state goes to ENTRY.
  - `confirm_pulse` is ignored.
- ERR:
  - `error` = 1; `show` and `mask` hold their entry values.
  - Only `clear_pulse` leaves this state.
- `conv_done` or `conv_error` outside WAIT is ignored.

## Timing
- Confirm to request: `confirm_pulse` sampled at edge N, then `conv_req` is high during cycle N+1 and `busy` rises at N+1.
- Result to display: `conv_done` sampled at edge M, then `show`, `mask` and `state` are updated at M+1 and `busy` falls at M+1.
- All outputs are registered, with no combinational path from input to output.
- Input pulses are level-sampled each cycle; a pulse held for k cycles counts as k events.
- WAIT counter:
  - Cleared on entry to WAIT.
  - Counts every WAIT cycle and saturates.
  - 16 bits wide.

## Configuration
- `CONV_SEQ_TIMEOUT_EN` defined:
  - The watchdog is compiled in: when the counter reaches TIMEOUT-1 without `conv_done` or `conv_error`, the state goes to ERR on the next edge.
  - A `conv_done` arriving in that same cycle wins over the timeout.
- Undefined: no counter is built and WAIT holds indefinitely until `conv_done`, `conv_error` or `clear_pulse`.

## Test plan
- Digit entry and conversion:
  - Stimulus: reset, enter A, B, C, D, then confirm.
  - Required: `conv_data` = 16'hABCD, mask = 8'h0F, a single-cycle `conv_req` one cycle after confirm, and `busy` = 1.
- Full entry:
  - Stimulus: with DIGITS=4, send a fifth enter with value 5.
  - Required: entry stays 0xABCD and the count stays 4.
- Result display and new entry:
  - Stimulus: in WAIT, `conv_done` with result 16'h4B3C.
  - Required: next cycle `show` = 32'h00004B3C, mask = 8'h0F, state = SHOW.
  - Stimulus: then enter 7.
  - Required: `show` = 32'h7, mask = 8'h01.
- Simultaneous done and error:
  - Stimulus: `conv_done` and `conv_error` in the same WAIT cycle.
  - Required: state = ERR and `error` = 1.
  - Stimulus: then `clear_pulse`.
  - Required: all outputs are zero.
- Clear during WAIT:
  - Stimulus: `clear_pulse` in WAIT, followed 3 cycles later by `conv_done`.
  - Required: the state remains ENTRY and `show` = 0.
- Watchdog:
  - Stimulus: with `CONV_SEQ_TIMEOUT_EN` and TIMEOUT=16, give no response in WAIT.
  - Required: ERR is entered exactly 16 cycles after WAIT entry.
  - Without the macro: the state is still WAIT after 1000 cycles.
